// File: rtl/shift_register_unit_if.sv
// Command/status bundle between the datapath controller and the shift register.
interface shift_register_unit_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
);
  logic               go;
  logic [2:0]         func;
  logic [WIDTH-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
  logic               ser_in;
  logic               abort;
  logic [WIDTH-1:0]   out;
  logic               carry_out;
  logic               busy;
  logic               done;
  logic               zero;

  // Controller side: issues commands, observes register state.
  modport master (
    output go, func, in, shamt, ser_in, abort,
    input  out, carry_out, busy, done, zero
  );

  // Register side.
  modport slave (
    input  go, func, in, shamt, ser_in, abort,
    output out, carry_out, busy, done, zero
  );
endinterface

// File: rtl/shift_register_unit.sv
// WIDTH-bit operand register with load/clear and multi-cycle shifts/rotates,
// one bit per clock, busy/done handshake and abort.
module shift_register_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_register_unit_if.slave bus
);

  localparam logic [2:0] FN_HOLD  = 3'b000;
  localparam logic [2:0] FN_LOAD  = 3'b001;
  localparam logic [2:0] FN_SHR   = 3'b010;
  localparam logic [2:0] FN_CLEAR = 3'b011;
  localparam logic [2:0] FN_SHL   = 3'b100;
  localparam logic [2:0] FN_ASR   = 3'b101;
  localparam logic [2:0] FN_ROR   = 3'b110;
  localparam logic [2:0] FN_ROL   = 3'b111;

  logic [WIDTH-1:0]   out_q,   out_d;
  logic               carry_q, carry_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]         op_q,    op_d;
  logic [WIDTH:0]     step_res;
  logic [2:0]         step_op;

  // One-bit step; returns {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                            input logic [WIDTH-1:0] v,
                                            input logic s);
    case (op)
      FN_SHR:  step_f = {v[0],       s,          v[WIDTH-1:1]};
      FN_SHL:  step_f = {v[WIDTH-1], v[WIDTH-2:0], s};
      FN_ASR:  step_f = {v[0],       v[WIDTH-1], v[WIDTH-1:1]};
      FN_ROR:  step_f = {v[0],       v[0],       v[WIDTH-1:1]};
      FN_ROL:  step_f = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      default: step_f = {1'b0,       v};
    endcase
  endfunction

  // The first step uses the freshly issued opcode, later steps the captured one.
  assign step_op  = busy_q ? op_q : bus.func;
  assign step_res = step_f(step_op, out_q, bus.ser_in);

  // Next-state: command acceptance, stepping, abort.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (busy_q) begin
      if (bus.abort) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        out_d   = step_res[WIDTH-1:0];
        carry_d = step_res[WIDTH];
        cnt_d   = SHAMT_W'(cnt_q - SHAMT_W'(1));
        if (cnt_q == SHAMT_W'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (bus.go) begin
      case (bus.func)
        FN_HOLD: ;
        FN_LOAD: begin
          out_d   = bus.in;
          carry_d = 1'b0;
          done_d  = 1'b1;
        end
        FN_CLEAR: begin
          out_d   = '0;
          carry_d = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          if (bus.shamt == '0) begin
            done_d = 1'b1;
          end else begin
            out_d   = step_res[WIDTH-1:0];
            carry_d = step_res[WIDTH];
            op_d    = bus.func;
            cnt_d   = SHAMT_W'(bus.shamt - SHAMT_W'(1));
            if (bus.shamt == SHAMT_W'(1)) done_d = 1'b1;
            else                           busy_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= FN_HOLD;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.zero      = (out_q == '0);

endmodule

// File: tb/tb_shift_register_unit.sv
// Directed bench for shift_register_unit: vector table plus corner sequences.
module tb_shift_register_unit;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHAMT_W = 4;
  localparam int NO_DONE = 40;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHR = 3'd2, CLR = 3'd3,
                         SHL = 3'd4, ASR = 3'd5, ROR = 3'd6, ROL = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_register_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_register_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] func;
    logic [7:0] pre;
    logic [7:0] din;
    logic [3:0] shamt;
    logic       ser;
    logic [7:0] exp_out;
    logic       exp_c;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  // Command fields are scrambled right after acceptance to prove they were captured.
  task automatic issue(input logic [2:0] f, input logic [7:0] d,
                       input logic [3:0] s, input logic ser);
    bus.go     = 1'b1;
    bus.func   = f;
    bus.in     = d;
    bus.shamt  = s;
    bus.ser_in = ser;
    @(posedge clk);
    #1;
    bus.go    = 1'b0;
    bus.func  = LOAD;
    bus.in    = 8'h5A;
    bus.shamt = 4'd0;
    @(negedge clk);
  endtask

  // Counts edges from acceptance until done is seen, and busy cycles on the way.
  task automatic wait_done(output int lat, output int bsy);
    lat = 1;
    bsy = 0;
    while (bus.done !== 1'b1 && lat < NO_DONE) begin
      if (bus.busy === 1'b1) bsy++;
      tick();
      lat++;
    end
  endtask

  task automatic preload(input logic [7:0] v);
    int lat, bsy;
    issue(LOAD, v, 4'd0, 1'b0);
    wait_done(lat, bsy);
  endtask

  initial begin
    int lat, bsy;
    logic seen;

    vecs[0]  = '{SHR,  8'hA5, 8'h00, 4'd3,  1'b0, 8'h14, 1'b1, 3,       2};
    vecs[1]  = '{ASR,  8'h90, 8'h00, 4'd2,  1'b0, 8'hE4, 1'b0, 2,       1};
    vecs[2]  = '{ROL,  8'h81, 8'h00, 4'd9,  1'b0, 8'h03, 1'b1, 9,       8};
    vecs[3]  = '{SHR,  8'h3C, 8'h00, 4'd0,  1'b0, 8'h3C, 1'b0, 1,       0};
    vecs[4]  = '{CLR,  8'h5A, 8'h00, 4'd0,  1'b0, 8'h00, 1'b0, 1,       0};
    vecs[5]  = '{ROR,  8'h01, 8'h00, 4'd1,  1'b0, 8'h80, 1'b1, 1,       0};
    vecs[6]  = '{SHL,  8'h0F, 8'h00, 4'd4,  1'b1, 8'hFF, 1'b0, 4,       3};
    vecs[7]  = '{ASR,  8'h80, 8'h00, 4'd15, 1'b0, 8'hFF, 1'b1, 15,      14};
    vecs[8]  = '{SHR,  8'hC3, 8'h00, 4'd10, 1'b1, 8'hFF, 1'b1, 10,      9};
    vecs[9]  = '{LOAD, 8'h12, 8'h00, 4'd0,  1'b0, 8'h00, 1'b0, 1,       0};
    vecs[10] = '{ROR,  8'h96, 8'h00, 4'd3,  1'b0, 8'hD2, 1'b1, 3,       2};
    vecs[11] = '{HOLD, 8'h81, 8'h00, 4'd0,  1'b0, 8'h81, 1'b0, NO_DONE, 0};
    vecs[12] = '{SHL,  8'h81, 8'h00, 4'd8,  1'b0, 8'h00, 1'b1, 8,       7};

    bus.go = 1'b0; bus.func = HOLD; bus.in = '0; bus.shamt = '0;
    bus.ser_in = 1'b0; bus.abort = 1'b0;

    // Reset state.
    #12;
    check("rst_out",   32'(bus.out), 32'h00);
    check("rst_carry", 32'(bus.carry_out), 32'h0);
    check("rst_busy",  32'(bus.busy), 32'h0);
    check("rst_done",  32'(bus.done), 32'h0);
    check("rst_zero",  32'(bus.zero), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven operations.
    for (int i = 0; i < 13; i++) begin
      preload(vecs[i].pre);
      issue(vecs[i].func, vecs[i].din, vecs[i].shamt, vecs[i].ser);
      wait_done(lat, bsy);
      check($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy", i),  32'(bsy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_out", i),   32'(bus.out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_carry", i), 32'(bus.carry_out), 32'(vecs[i].exp_c));
      check($sformatf("v%0d_zero", i),  32'(bus.zero), 32'(vecs[i].exp_out == 8'h00));
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'h0);
      check($sformatf("v%0d_hold", i), 32'(bus.out), 32'(vecs[i].exp_out));
    end

    // go during busy is ignored.
    preload(8'h81);
    issue(ROL, 8'h00, 4'd9, 1'b0);
    bus.go = 1'b1; bus.func = LOAD; bus.in = 8'h55; bus.shamt = 4'd1;
    @(posedge clk);
    #1 bus.go = 1'b0;
    @(negedge clk);
    wait_done(lat, bsy);
    check("ign_lat",   32'(lat + 1), 32'd9);
    check("ign_out",   32'(bus.out), 32'h03);
    check("ign_carry", 32'(bus.carry_out), 32'h1);

    // Abort on the third edge after acceptance of SHL 6.
    tick();
    preload(8'hFF);
    issue(SHL, 8'h00, 4'd6, 1'b0);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_out",   32'(bus.out), 32'hF8);
    check("abort_carry", 32'(bus.carry_out), 32'h1);
    check("abort_busy",  32'(bus.busy), 32'h0);
    check("abort_done",  32'(bus.done), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    check("abort_keep",    32'(bus.out), 32'hF8);

    // Abort while idle does nothing.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle_abort_out", 32'(bus.out), 32'hF8);

    // Asynchronous reset mid-shift.
    preload(8'hFF);
    issue(SHR, 8'h00, 4'd5, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out",   32'(bus.out), 32'h00);
    check("arst_busy",  32'(bus.busy), 32'h0);
    check("arst_done",  32'(bus.done), 32'h0);
    check("arst_carry", 32'(bus.carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    check("arst_quiet", 32'(seen), 32'h0);
    check("arst_out2",  32'(bus.out), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
